// File: rtl/bandpass3_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : bandpass3_ctl
//  Purpose  : Coefficient-change sequencer for a bandpass filter. A new
//             cm1/d pair is taken on a valid/ready handshake. The filter state
//             is flushed, the pair is loaded, and the output is gated while the
//             filter settles. A one-cycle done pulse marks completion.
//  Option   : define BANDPASS3_CTL_CLIP_EN to add the clip_cnt output, a
//             saturating count of full-scale filter output samples.
//  Revision : 1.0 - initial release
// ============================================================================
module bandpass3_ctl #(
  parameter int unsigned FLUSH_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 64,
  parameter int          CM1_INIT   = 7510,
  parameter int          D_INIT     = -23395
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic signed [16:0] req_cm1,
  input  logic signed [16:0] req_d,
  output logic signed [16:0] cm1,
  output logic signed [16:0] d,
  output logic               zerome,
  output logic               oe,
  output logic               busy,
  output logic               done,
  input  logic signed [17:0] filt_out
`ifdef BANDPASS3_CTL_CLIP_EN
  ,
  output logic [7:0]         clip_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic [7:0]         FLUSH_LOAD  = 8'(FLUSH_CYC - 1);
  localparam logic [7:0]         SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic signed [16:0] CM1_RST     = 17'(CM1_INIT);
  localparam logic signed [16:0] D_RST       = 17'(D_INIT);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic signed [16:0] sh_cm1_q, sh_cm1_d;
  logic signed [16:0] sh_d_q, sh_d_d;
  logic signed [16:0] cm1_q, cm1_d;
  logic signed [16:0] d_q, d_d;
  logic               zerome_q, zerome_d;
  logic               oe_q, oe_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept;

  // Handshake: ready is high exactly while the registered state is IDLE.
  assign accept = req_valid & ready_q;

  // Next-state, phase counter, shadow/coefficient and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_cm1_d = sh_cm1_q;
    sh_d_d   = sh_d_q;
    cm1_d    = cm1_q;
    d_d      = d_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_FLUSH;
          cnt_d    = FLUSH_LOAD;
          sh_cm1_d = req_cm1;
          sh_d_d   = req_d;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_LOAD;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_LOAD: begin
        // LOAD is a single cycle; the coefficients change on its exit edge.
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_LOAD;
        cm1_d   = sh_cm1_q;
        d_d     = sh_d_q;
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_FLUSH;
        cnt_d   = FLUSH_LOAD;
      end
    endcase
    // Outputs are registered from the next state so they align with state_q.
    zerome_d = (state_d == ST_FLUSH) || (state_d == ST_LOAD);
    oe_d     = (state_d == ST_IDLE);
    ready_d  = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_q == ST_SETTLE) && (state_d == ST_IDLE);
  end

  // State and output registers; reset restarts a full sequence on init values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FLUSH;
      cnt_q    <= FLUSH_LOAD;
      sh_cm1_q <= CM1_RST;
      sh_d_q   <= D_RST;
      cm1_q    <= CM1_RST;
      d_q      <= D_RST;
      zerome_q <= 1'b1;
      oe_q     <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_cm1_q <= sh_cm1_d;
      sh_d_q   <= sh_d_d;
      cm1_q    <= cm1_d;
      d_q      <= d_d;
      zerome_q <= zerome_d;
      oe_q     <= oe_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign req_ready = ready_q;
  assign cm1       = cm1_q;
  assign d         = d_q;
  assign zerome    = zerome_q;
  assign oe        = oe_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef BANDPASS3_CTL_CLIP_EN
  logic [7:0] clip_q;
  logic       clip_hit;

  // Full-scale sample in either direction while the filter output is live.
  assign clip_hit = oe_q && ((filt_out == 18'sh1FFFF) || (filt_out == 18'sh20000));

  // Saturating clip counter; a new request clears it ahead of any increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_q <= 8'd0;
    end else if (accept) begin
      clip_q <= 8'd0;
    end else if (clip_hit && (clip_q != 8'hFF)) begin
      clip_q <= clip_q + 8'd1;
    end
  end

  assign clip_cnt = clip_q;
`else
  logic w_unused_filt;
  assign w_unused_filt = ^filt_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bandpass3_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bandpass3_ctl
//  Purpose  : Directed self-checking bench for bandpass3_ctl: reset sequence,
//             single request, ignored request while busy, back-to-back
//             requests, reset mid-settle, and (when compiled in) clip counting.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bandpass3_ctl;

  logic               clk;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic signed [16:0] req_cm1;
  logic signed [16:0] req_d;
  logic signed [16:0] cm1;
  logic signed [16:0] d;
  logic               zerome;
  logic               oe;
  logic               busy;
  logic               done;
  logic signed [17:0] filt_out;
`ifdef BANDPASS3_CTL_CLIP_EN
  logic [7:0]         clip_cnt;
`endif

  int n_tests;
  int n_fail;

  bandpass3_ctl u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cm1   (req_cm1),
    .req_d     (req_d),
    .cm1       (cm1),
    .d         (d),
    .zerome    (zerome),
    .oe        (oe),
    .busy      (busy),
    .done      (done),
    .filt_out  (filt_out)
`ifdef BANDPASS3_CTL_CLIP_EN
    ,
    .clip_cnt  (clip_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk cycles 1..70 after an accepting (or final reset) edge, checking every
  // output against the fixed timeline. Ends in cycle 70 without advancing.
  task automatic run_seq(input longint oc, input longint od,
                         input longint nc, input longint nd,
                         input int drop_at);
    for (int k = 1; k <= 70; k++) begin
      check($sformatf("c%0d zerome", k), longint'(zerome), (k <= 5) ? 1 : 0);
      check($sformatf("c%0d oe", k), longint'(oe), (k >= 70) ? 1 : 0);
      check($sformatf("c%0d busy", k), longint'(busy), (k <= 69) ? 1 : 0);
      check($sformatf("c%0d ready", k), longint'(req_ready), (k >= 70) ? 1 : 0);
      check($sformatf("c%0d done", k), longint'(done), (k == 70) ? 1 : 0);
      check($sformatf("c%0d cm1", k), longint'(cm1), (k <= 5) ? oc : nc);
      check($sformatf("c%0d d", k), longint'(d), (k <= 5) ? od : nd);
      if (k == drop_at) req_valid = 1'b0;
      if (k < 70) tick();
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_cm1   = '0;
    req_d     = '0;
    filt_out  = '0;

    // Reset held for three edges.
    repeat (3) tick();
    check("rst cm1", longint'(cm1), 7510);
    check("rst d", longint'(d), -23395);
    check("rst zerome", longint'(zerome), 1);
    check("rst oe", longint'(oe), 0);
    check("rst ready", longint'(req_ready), 0);
    check("rst busy", longint'(busy), 1);
    check("rst done", longint'(done), 0);
    rst = 1'b0;
    run_seq(7510, -23395, 7510, -23395, 0);

    tick();
    check("idle done", longint'(done), 0);
    check("idle ready", longint'(req_ready), 1);
    check("idle oe", longint'(oe), 1);

    // Single request; a second pair held during busy must be ignored.
    req_valid = 1'b1;
    req_cm1   = 17'sd8000;
    req_d     = -17'sd20000;
    tick();
    req_cm1 = 17'sd1;
    req_d   = 17'sd1;
    run_seq(7510, -23395, 8000, -20000, 60);
    tick();
    check("ign cm1", longint'(cm1), 8000);
    check("ign d", longint'(d), -20000);
    check("ign busy", longint'(busy), 0);

    // Back-to-back: valid held high, new pair accepted on the done cycle.
    req_valid = 1'b1;
    req_cm1   = 17'sd100;
    req_d     = -17'sd100;
    tick();
    req_cm1 = 17'sd200;
    req_d   = -17'sd200;
    run_seq(8000, -20000, 100, -100, 0);
    tick();
    req_cm1 = 17'sd300;
    req_d   = -17'sd300;
    run_seq(100, -100, 200, -200, 69);
    tick();
    check("b2b busy", longint'(busy), 0);
    check("b2b cm1", longint'(cm1), 200);
    check("b2b d", longint'(d), -200);

    // Reset pulsed in the third SETTLE cycle.
    req_valid = 1'b1;
    req_cm1   = 17'sd500;
    req_d     = -17'sd500;
    tick();
    req_valid = 1'b0;
    repeat (7) tick();
    check("mid cm1", longint'(cm1), 500);
    check("mid d", longint'(d), -500);
    rst = 1'b1;
    tick();
    check("mrst cm1", longint'(cm1), 7510);
    check("mrst d", longint'(d), -23395);
    check("mrst busy", longint'(busy), 1);
    check("mrst zerome", longint'(zerome), 1);
    check("mrst oe", longint'(oe), 0);
    check("mrst done", longint'(done), 0);
    rst = 1'b0;
    run_seq(7510, -23395, 7510, -23395, 0);

`ifdef BANDPASS3_CTL_CLIP_EN
    tick();
    check("clip start", longint'(clip_cnt), 0);
    filt_out = 18'sd131071;
    repeat (300) tick();
    check("clip sat", longint'(clip_cnt), 255);
    req_valid = 1'b1;
    req_cm1   = 17'sd8000;
    req_d     = -17'sd20000;
    tick();
    req_valid = 1'b0;
    check("clip clr", longint'(clip_cnt), 0);
    run_seq(7510, -23395, 8000, -20000, 0);
    check("clip oe0", longint'(clip_cnt), 0);
    filt_out = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
